// File: rtl/biquad_coeff_sequencer.sv
// biquad_coeff_sequencer
// Stages a coefficient set written over a small config bus and, on commit, streams it into
// the downstream biquad's cascaded DSP B-register chain (highest address first), one
// coefficient per 2-cycle slot, followed by a single update pulse that switches all DSPs
// to the new set at once.
//
// Ports:
//   clk            sole clock
//   rst            asynchronous, active-high reset
//   cfg_adr_i      staging address (addresses >= NCOEFF are ignored)
//   cfg_dat_i      staging write data
//   cfg_wr_i       staging write strobe
//   commit_i       request to stream the staging set
//   coeff_dat_o    coefficient data to the biquad
//   coeff_wr_o     coefficient shift strobe to the biquad (first cycle of each slot)
//   coeff_update_o one-cycle pulse making the shifted set live
//   busy_o         stream in progress (staging writes are refused)
//   err_o          sticky: a staging write arrived while busy
module biquad_coeff_sequencer #(
  parameter int unsigned NCOEFF  = 2,
  parameter int unsigned CBITS   = 18,
  parameter int unsigned ADRBITS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADRBITS-1:0] cfg_adr_i,
  input  logic [CBITS-1:0]   cfg_dat_i,
  input  logic               cfg_wr_i,
  input  logic               commit_i,
  output logic [CBITS-1:0]   coeff_dat_o,
  output logic               coeff_wr_o,
  output logic               coeff_update_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SLOT_A = 2'd1;
  localparam logic [1:0] SLOT_B = 2'd2;
  localparam logic [1:0] UPDATE = 2'd3;

  localparam logic [ADRBITS-1:0] LAST_IDX = ADRBITS'(NCOEFF - 1);

  logic [CBITS-1:0]   r_stage [NCOEFF];
  logic [1:0]         r_state;
  logic [ADRBITS-1:0] r_idx;
  logic               r_pend;
  logic               r_err;
  logic [CBITS-1:0]   r_dat;

  logic               w_busy;
  logic               w_adr_ok;
  logic               w_stage_wr;
  logic [CBITS-1:0]   w_first_dat;
  logic [1:0]         w_state_d;
  logic [ADRBITS-1:0] w_idx_d;
  logic               w_pend_d;
  logic [CBITS-1:0]   w_dat_d;

  assign w_busy     = (r_state != IDLE);
  assign w_adr_ok   = (32'(cfg_adr_i) < NCOEFF);
  assign w_stage_wr = cfg_wr_i && !w_busy && w_adr_ok;

  // A write landing on the same edge as the stream start must already be in the first slot.
  assign w_first_dat = (w_stage_wr && (cfg_adr_i == LAST_IDX)) ? cfg_dat_i : r_stage[LAST_IDX];

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_dat_d   = r_dat;
    // Commits during a stream collapse into one pending restart.
    w_pend_d  = r_pend || (w_busy && commit_i);
    case (r_state)
      IDLE: begin
        if (commit_i || r_pend) begin
          w_state_d = SLOT_A;
          w_idx_d   = LAST_IDX;
          w_dat_d   = w_first_dat;
          w_pend_d  = 1'b0;
        end
      end
      SLOT_A: w_state_d = SLOT_B;
      SLOT_B: begin
        if (r_idx == '0) begin
          w_state_d = UPDATE;
        end else begin
          // Staging is frozen while busy, so reading it here gives a consistent snapshot.
          w_state_d = SLOT_A;
          w_idx_d   = r_idx - ADRBITS'(1);
          w_dat_d   = r_stage[r_idx - ADRBITS'(1)];
        end
      end
      UPDATE:  w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_pend  <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
      for (int i = 0; i < int'(NCOEFF); i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_pend  <= w_pend_d;
      r_dat   <= w_dat_d;
      if (w_stage_wr) begin
        r_stage[cfg_adr_i] <= cfg_dat_i;
      end
      if (cfg_wr_i && w_busy && w_adr_ok) begin
        r_err <= 1'b1;
      end
    end
  end

  assign coeff_dat_o    = r_dat;
  assign coeff_wr_o     = (r_state == SLOT_A);
  assign coeff_update_o = (r_state == UPDATE);
  assign busy_o         = w_busy;
  assign err_o          = r_err;

endmodule

// File: doc/biquad_coeff_sequencer.md
Name: biquad_coeff_sequencer

Overview:
- Upstream neighbour of the 8-sample incremental biquad.
- Holds a staged coefficient set written over a simple config bus.
- On commit, streams the set into the biquad's cascaded DSP B-register chain, highest address first, using the biquad's coeff_dat/coeff_wr/coeff_update interface, then fires a single update pulse that makes the new set live in all DSPs at once.
- The staging set can be rewritten safely while the old set is running.

Parameters:
- NCOEFF, 2, number of coefficients per set; equals the depth of the B cascade per DSP pair.
- CBITS, 18, coefficient width; matches the DSP B port.
- ADRBITS, 1, config address width; ceil(log2(NCOEFF)), minimum 1.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_adr_i  in  ADRBITS  staging address.
- cfg_dat_i  in  CBITS  staging write data.
- cfg_wr_i  in  1  staging write strobe, one entry per cycle.
- commit_i  in  1  request to stream the staging set into the biquad.
- coeff_dat_o  out  CBITS  to the biquad coeff_dat_i.
- coeff_wr_o  out  1  to the biquad coeff_wr_i.
- coeff_update_o  out  1  to the biquad coeff_update_i.
- busy_o  out  1  high from the cycle after an accepted commit until the cycle after the update pulse.
- err_o  out  1  sticky flag; set by a staging write while busy, cleared only by rst.

Behaviour:
- Reset (asynchronous, effective immediately):
  - All outputs 0; FSM to IDLE; pending-commit flag 0.
  - Staging registers reset to 0.
- Staging writes:
  - When cfg_wr_i is high, busy_o is low and cfg_adr_i < NCOEFF, the write lands on the next edge.
  - Addresses >= NCOEFF are ignored and do not set err_o.
  - While busy_o is high, writes are dropped and err_o is set.
- Streaming order: addresses stream from NCOEFF-1 down to 0, because the first value written ends up deepest in the cascade.
- Slot timing: each coefficient occupies a 2-cycle slot.
  - coeff_dat_o changes only at slot start and is held for both cycles.
  - coeff_wr_o is high in the first cycle of the slot only.
  - The biquad re-registers its write enable, so the data must stay stable for one cycle after coeff_wr_o.
- FSM states: IDLE, SLOT_A, SLOT_B, UPDATE.
  - IDLE -> SLOT_A on commit_i (or a pending commit). Load index = NCOEFF-1; busy_o goes high on the same edge.
  - SLOT_A: drive coeff_dat_o = stage[idx] and coeff_wr_o = 1, then go to SLOT_B.
  - SLOT_B: coeff_wr_o = 0, data held. If idx == 0, go to UPDATE; otherwise decrement idx and go to SLOT_A.
  - UPDATE: coeff_update_o = 1 for exactly one cycle; coeff_dat_o is held. Go to IDLE; busy_o drops on that edge.
- Latency: with commit_i sampled at edge 0:
  - First coeff_wr_o cycle follows edge 0.
  - Slot n starts at cycle 1+2n.
  - coeff_update_o is in cycle 1+2*NCOEFF.
  - busy_o is low from cycle 2+2*NCOEFF.
- Data snapshot: streamed values are read from staging during the stream. Because writes are blocked while busy, the stream is a consistent snapshot.
- commit_i while busy:
  - Sets a single pending flag; multiple commits collapse into one.
  - On leaving UPDATE, the FSM goes through IDLE for exactly one cycle with busy_o low, then restarts.
  - Staging writes in that IDLE cycle are accepted and are included in the restarted stream.
- Simultaneous cfg_wr_i and commit_i in IDLE: the write is accepted and the stream includes the new value.
- Reset mid-stream:
  - The stream aborts with no coeff_update_o, so the biquad keeps its old live set.
  - The partially shifted B1 chain is overwritten by the next full stream.
- coeff_dat_o in IDLE holds its last value; this has no functional effect.

Test Plan:
- Reset, write stage[0]=0x00011 and stage[1]=0x00022, commit at edge 0:
  - coeff_wr_o high in cycles 1 and 3.
  - coeff_dat_o = 0x00022 in cycles 1-2 and 0x00011 in cycles 3-4.
  - coeff_update_o high only in cycle 5; busy_o high cycles 1-5.
- Write during busy (cycle 2, addr 0, 0x3FFFF):
  - Stream is unchanged; err_o = 1 and stays 1.
  - A later write after busy clears lands in staging; err_o still 1 until rst.
- Commit pulses in cycles 2 and 4 of an active stream:
  - Exactly one extra stream runs, with busy_o low for exactly one cycle (cycle 6).
  - Second stream: coeff_wr_o in cycles 7 and 9, update in cycle 11.
- Assert rst in cycle 3 of a stream:
  - All outputs 0 immediately; no coeff_update_o.
  - A new commit yields a full 5-cycle stream of zeros (staging reset).
- Same-cycle cfg_wr_i (addr 1, 0x12345) and commit_i in IDLE: the first streamed value is 0x12345.
- NCOEFF=4, ADRBITS=2 build; write 1, 2, 3, 4 to addresses 0-3:
  - Stream order 4, 3, 2, 1 with coeff_wr_o in cycles 1, 3, 5, 7.
  - Update in cycle 9; a write to addr 4 is not possible with ADRBITS=2, so confirm wrap is not aliased in the NCOEFF=3 build (addr 3 ignored).
